sc_sng_array: RTL
=================

Name: sc_sng_array

Overview:
- Parallel stochastic number generator: converts N unsigned W-bit binary values into N parallel unipolar/bipolar bitstreams.
- It is the transmitting end of the stochastic datapath. It drives the per-lane din/weight bitstreams consumed by the APC neuron.
- One shared maximal-length LFSR is used. Each lane compares its value against a lane-rotated copy of the LFSR, so lanes are decorrelated.
- Values are loaded per frame over a valid/ready handshake. Each frame emits exactly L = 2**W - 1 bits per lane.

Parameters:
- N, 8, number of lanes (bitstreams)
- W, 8, value and LFSR width; legal range 4..12
- L, 2**W-1, frame length in bits (derived; not to be overridden)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  load_data/seed present
- load_ready  out  1  block accepts a frame this cycle
- load_data  in  N*W  lane i value = load_data[i*W +: W], unsigned
- seed  in  W  LFSR seed, sampled at acceptance
- en  in  1  advance enable; low pauses the stream
- bits  out  N  stochastic bits, one per lane
- bits_valid  out  1  bits carry a frame bit this cycle
- frame_start  out  1  first bit of frame (qualified by bits_valid)
- frame_last  out  1  last bit of frame (qualified by bits_valid)
- busy  out  1  state == RUN

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, bits=0, bits_valid=0, frame_start=0, frame_last=0.
  - Internal cnt=0, lfsr=1.
  - Applies mid-frame too: the frame is abandoned and nothing more is emitted.
- States:
  - IDLE: load_ready=1.
  - RUN: load_ready = en && (cnt == L-1), enabling gapless back-to-back frames.
- Acceptance = load_valid && load_ready at an edge. On that edge:
  - vals <= load_data.
  - lfsr <= (seed==0 ? 1 : seed).
  - cnt <= 0.
  - state <= RUN.
  - If accepted from IDLE: bits_valid <= 0 at that edge.
- RUN edge with en=1:
  - bits[i] <= (vals[i] >= rotl(lfsr, i mod W)).
  - bits_valid <= 1.
  - frame_start <= (cnt==0).
  - frame_last <= (cnt==L-1).
  - lfsr <= next(lfsr).
  - cnt <= cnt+1.
- After the edge with cnt==L-1:
  - With acceptance: reload as above and stay in RUN. The next enabled edge emits bit 0 of the new frame, with no bubble.
  - Without acceptance: go to IDLE. The following edge drives bits_valid=0 and bits=0.
- RUN edge with en=0: bits_valid <= 0, frame_start <= 0, frame_last <= 0. bits, lfsr and cnt hold.
- Latency: first valid bit appears on the first enabled edge after the acceptance edge, i.e. 1 cycle minimum.
- LFSR:
  - Fibonacci, shift left: next = {lfsr[W-2:0], XOR of taps}.
  - Taps (1-based bit positions):
    - W4: 4,3
    - W5: 5,3
    - W6: 6,5
    - W7: 7,6
    - W8: 8,6,5,4
    - W9: 9,5
    - W10: 10,7
    - W11: 11,9
    - W12: 12,6,4,1
  - Never reaches 0. The period is exactly L.
- Exactness:
  - Rotation permutes nonzero values, so every lane sees rnd in 1..L exactly once per frame.
  - Ones count per lane per frame == vals[i] exactly.
  - vals=0 gives all zeros; vals=L gives all ones.
  - Bipolar interpretation for the neuron: x = 2*v/L - 1.
- load_data and seed are ignored unless accepted. vals are stable for the whole frame.
- Simultaneous reset and load_valid: reset wins and nothing is accepted.
- Illegal W: elaboration-time assertion fails.

Test Plan:
- Reset sequence: hold reset 3 cycles while load_valid=1 -> load_ready sampled after reset =1; bits_valid=0, busy=0, bits=0; no frame started.
- W=4, N=4, seed=1, vals={0,5,10,15}, en=1 -> exactly 15 consecutive bits_valid cycles.
  - frame_start on the 1st valid cycle, frame_last on the 15th.
  - Per-lane ones counts 0, 5, 10, 15.
  - Lane 0 first bits follow lfsr 1,2,4,9,3: for v=5 the bits are 1,1,1,0,1.
- Back-to-back frames: present a second load (vals={15,0,7,8}) with load_valid held -> accepted on the cnt==14 edge; no bits_valid gap; new frame counts 15, 0, 7, 8.
- Pause: toggle en pseudo-randomly during a frame -> bits_valid low on en=0 cycles; bits held; total valid bits still 15; counts still exact.
- Seed 0 -> behaves identically to seed 1. Seed 7 -> lane counts unchanged, and the bit sequence for lane 0 starts with rnd=7.
- Reset asserted at cnt=6 -> next cycle bits_valid=0, state IDLE, load_ready=1. A subsequent load runs a full clean 15-bit frame.

Source files
------------

// File: rtl/sc_sng_array_if.sv
// ---------------------------------------------------------------------------
// sc_sng_array_if
// Load handshake and bitstream bus of the parallel stochastic number
// generator.
//   master : drives load_valid/load_data/seed/en, observes everything else
//   slave  : the generator itself
// Signals:
//   load_valid  frame values and seed present
//   load_ready  generator accepts a frame this cycle
//   load_data   N lanes of W-bit unsigned values, lane i at [i*W +: W]
//   seed        LFSR seed, used only at acceptance
//   en          advance enable, low pauses the stream
//   bits        one stochastic bit per lane
//   bits_valid  bits carry a frame bit this cycle
//   frame_start first bit of a frame (qualified by bits_valid)
//   frame_last  last bit of a frame (qualified by bits_valid)
//   busy        a frame is in progress
// ---------------------------------------------------------------------------
interface sc_sng_array_if #(
    parameter int N = 8,
    parameter int W = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [N*W-1:0]   load_data;
    logic [W-1:0]     seed;
    logic             en;
    logic [N-1:0]     bits;
    logic             bits_valid;
    logic             frame_start;
    logic             frame_last;
    logic             busy;

    modport master (
        output load_valid, load_data, seed, en,
        input  load_ready, bits, bits_valid, frame_start, frame_last, busy
    );

    modport slave (
        input  load_valid, load_data, seed, en,
        output load_ready, bits, bits_valid, frame_start, frame_last, busy
    );
endinterface

// File: rtl/sc_sng_array.sv
// ---------------------------------------------------------------------------
// sc_sng_array
// Parallel stochastic number generator. N unsigned W-bit values are loaded
// per frame and turned into N bitstreams of exactly L = 2**W-1 bits each.
// A single maximal-length Fibonacci LFSR is shared; lane i compares its
// value against the LFSR rotated left by (i mod W), which decorrelates the
// lanes while still presenting every nonzero value once per frame, so the
// ones count of lane i over a frame equals its loaded value exactly.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   sng    sc_sng_array_if.slave (load handshake, enable, bitstream outputs)
// ---------------------------------------------------------------------------
module sc_sng_array #(
    parameter  int N = 8,
    parameter  int W = 8,
    localparam int L = (1 << W) - 1
) (
    input  logic             clk,
    input  logic             reset,
    sc_sng_array_if.slave    sng
);

    generate
        if ((W < 4) || (W > 12)) begin : g_bad_w
            $error("sc_sng_array: W must lie in 4..12");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [W-1:0] ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

    // Feedback bit of the maximal-length tap set for the configured width.
    function automatic logic lfsr_fb(input logic [W-1:0] x);
        logic [11:0] xe;
        logic        fb;
        xe = 12'(x);
        case (W)
            32'sd4:  fb = xe[3] ^ xe[2];
            32'sd5:  fb = xe[4] ^ xe[2];
            32'sd6:  fb = xe[5] ^ xe[4];
            32'sd7:  fb = xe[6] ^ xe[5];
            32'sd8:  fb = xe[7] ^ xe[5] ^ xe[4] ^ xe[3];
            32'sd9:  fb = xe[8] ^ xe[4];
            32'sd10: fb = xe[9] ^ xe[6];
            32'sd11: fb = xe[10] ^ xe[8];
            32'sd12: fb = xe[11] ^ xe[5] ^ xe[3] ^ xe[0];
            default: fb = 1'b0;
        endcase
        return fb;
    endfunction

    state_e           state_q;
    logic [N*W-1:0]   vals_q;
    logic [W-1:0]     lfsr_q;
    logic [W-1:0]     cnt_q;
    logic [N-1:0]     bits_q;
    logic             bits_valid_q;
    logic             frame_start_q;
    logic             frame_last_q;

    logic [W-1:0]     lfsr_d;
    logic [W-1:0]     seed_d;
    logic [N-1:0]     bits_d;
    logic             at_last_s;
    logic             ready_s;
    logic             accept_s;

    // Per-lane comparator against the lane-rotated LFSR value.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int ROT = gi % W;
        logic [W-1:0] rnd_s;
        // A shift by W yields zero, so ROT == 0 degenerates to lfsr_q.
        assign rnd_s      = (lfsr_q << ROT) | (lfsr_q >> (W - ROT));
        assign bits_d[gi] = (vals_q[gi*W +: W] >= rnd_s);
    end

    // Next LFSR value, seed sanitising and handshake decode.
    always_comb begin
        lfsr_d    = {lfsr_q[W-2:0], lfsr_fb(lfsr_q)};
        // A zero seed would lock the LFSR, so it is replaced by 1.
        seed_d    = (sng.seed == ZERO_W) ? ONE_W : sng.seed;
        at_last_s = (cnt_q == CNT_LAST);
        // In RUN a new frame is taken only on the edge that emits the last
        // bit, which lets consecutive frames abut without a bubble.
        ready_s   = (state_q == ST_IDLE) || (sng.en && at_last_s);
        accept_s  = sng.load_valid && ready_s;
    end

    // Frame sequencer: acceptance, bit emission, pause and frame wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            vals_q        <= {(N*W){1'b0}};
            lfsr_q        <= ONE_W;
            cnt_q         <= ZERO_W;
            bits_q        <= {N{1'b0}};
            bits_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bits_q        <= {N{1'b0}};
                    bits_valid_q  <= 1'b0;
                    frame_start_q <= 1'b0;
                    frame_last_q  <= 1'b0;
                    if (accept_s) begin
                        vals_q  <= sng.load_data;
                        lfsr_q  <= seed_d;
                        cnt_q   <= ZERO_W;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (sng.en) begin
                        bits_q        <= bits_d;
                        bits_valid_q  <= 1'b1;
                        frame_start_q <= (cnt_q == ZERO_W);
                        frame_last_q  <= at_last_s;
                        lfsr_q        <= lfsr_d;
                        cnt_q         <= cnt_q + ONE_W;
                        if (at_last_s) begin
                            if (accept_s) begin
                                // Reload overrides the advance above.
                                vals_q  <= sng.load_data;
                                lfsr_q  <= seed_d;
                                cnt_q   <= ZERO_W;
                                state_q <= ST_RUN;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        // Paused: bits, lfsr and cnt hold.
                        bits_valid_q  <= 1'b0;
                        frame_start_q <= 1'b0;
                        frame_last_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    bits_q        <= {N{1'b0}};
                    bits_valid_q  <= 1'b0;
                    frame_start_q <= 1'b0;
                    frame_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sng.load_ready  = ready_s;
    assign sng.bits        = bits_q;
    assign sng.bits_valid  = bits_valid_q;
    assign sng.frame_start = frame_start_q;
    assign sng.frame_last  = frame_last_q;
    assign sng.busy        = (state_q == ST_RUN);

endmodule
